// File: rtl/frame_sync_if.sv
// rtl/frame_sync_if.sv - bit-in / word-out stream bundle for the frame synchronizer
interface frame_sync_if;
    logic        in_valid;
    logic        in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/frame_sync.sv
// rtl/frame_sync.sv - 102-bit frame aligner, deframer and 32-bit payload repacker
module frame_sync #(
    parameter int CONFIRM_CNT = 2,
    parameter int LOSS_CNT    = 3,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    frame_sync_if.slave  s,
    output logic         locked,
    output logic         overflow
);
    localparam int            AW       = $clog2(FIFO_DEPTH);
    localparam logic [2:0]    CONF_W   = 3'(CONFIRM_CNT);
    localparam logic [2:0]    LOSS_W   = 3'(LOSS_CNT);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t        state_q, state_d;
    logic [5:0]    hdr_q, hdr_d;
    logic [6:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]    good_q, good_d;
    logic [2:0]    miss_q, miss_d;
    logic          data_q, data_d;
    logic [30:0]   word_q, word_d;
    logic          in_ready_q;
    logic          locked_q;
    logic          ovf_q;
    logic          push;
    logic [31:0]   push_word;

    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;

    logic          accept;
    logic [5:0]    win;
    logic          win_zero, win_one;
    logic [6:0]    bit_nxt;
    logic          pop, full, can_push;

    assign accept    = s.in_valid && in_ready_q;
    assign win       = {hdr_q[4:0], s.in_data};
    assign win_zero  = (win == 6'b000000);
    assign win_one   = (win == 6'b111111);
    assign bit_nxt   = (bit_cnt_q == 7'd101) ? 7'd0 : bit_cnt_q + 7'd1;
    assign push_word = {word_q, s.in_data};

    assign pop       = (cnt_q != '0) && s.out_ready;
    assign full      = (cnt_q == FULL_CNT);
    assign can_push  = push && (!full || pop);

    assign s.in_ready  = in_ready_q;
    assign s.out_valid = (cnt_q != '0);
    assign s.out_data  = mem_q[rd_q];
    assign locked      = locked_q;
    assign overflow    = ovf_q;

    // Alignment search/confirm/hold decisions and payload packing, all gated on an accepted bit
    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        bit_cnt_d = bit_cnt_q;
        good_d    = good_q;
        miss_d    = miss_q;
        data_d    = data_q;
        word_d    = word_q;
        push      = 1'b0;
        if (accept) begin
            hdr_d = win;
            case (state_q)
                HUNT: begin
                    if (win_zero || win_one) begin
                        bit_cnt_d = 7'd6;
                        good_d    = 3'd1;
                        if (CONFIRM_CNT == 1) begin
                            state_d = LOCKED;
                            data_d  = win_zero;
                            miss_d  = 3'd0;
                        end else begin
                            state_d = VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    bit_cnt_d = bit_nxt;
                    if (bit_cnt_q == 7'd5) begin
                        if (win_zero || win_one) begin
                            good_d = good_q + 3'd1;
                            if (good_q + 3'd1 == CONF_W) begin
                                // The confirming frame is itself handled as a locked frame
                                state_d = LOCKED;
                                data_d  = win_zero;
                                miss_d  = 3'd0;
                            end
                        end else begin
                            state_d   = HUNT;
                            good_d    = 3'd0;
                            bit_cnt_d = 7'd0;
                        end
                    end
                end
                LOCKED: begin
                    bit_cnt_d = bit_nxt;
                    if (bit_cnt_q == 7'd5) begin
                        if (win_zero || win_one) begin
                            miss_d = 3'd0;
                            data_d = win_zero;
                        end else begin
                            data_d = 1'b0;
                            if (miss_q + 3'd1 == LOSS_W) begin
                                state_d   = HUNT;
                                miss_d    = 3'd0;
                                good_d    = 3'd0;
                                bit_cnt_d = 7'd0;
                            end else begin
                                miss_d = miss_q + 3'd1;
                            end
                        end
                    end else if (data_q && bit_cnt_q >= 7'd6) begin
                        word_d = {word_q[29:0], s.in_data};
                        if (bit_cnt_q == 7'd37 || bit_cnt_q == 7'd69 || bit_cnt_q == 7'd101)
                            push = 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Framing state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            hdr_q      <= '0;
            bit_cnt_q  <= '0;
            good_q     <= '0;
            miss_q     <= '0;
            data_q     <= 1'b0;
            word_q     <= '0;
            in_ready_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_q      <= hdr_d;
            bit_cnt_q  <= bit_cnt_d;
            good_q     <= good_d;
            miss_q     <= miss_d;
            data_q     <= data_d;
            word_q     <= word_d;
            in_ready_q <= 1'b1;
            locked_q   <= (state_d == LOCKED);
        end
    end

    // Output word buffer; a pop in the same cycle frees room for a push into a full buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            ovf_q <= push && !can_push;
            if (can_push) begin
                mem_q[wr_q] <= push_word;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            if (can_push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (!can_push && pop) cnt_q <= cnt_q - 1'b1;
        end
    end
endmodule

// File: tb/tb_frame_sync.sv
// tb/tb_frame_sync.sv - self-checking bench for frame_sync
module tb_frame_sync;
    typedef struct {
        logic [5:0]  hdr;
        logic [95:0] pay;
        bit          lock;
        int          emit;
    } frm_t;

    localparam logic [95:0] IDLE_P = {48{2'b10}};
    localparam logic [95:0] DATA1  = 96'hDEADBEEF_01234567_89ABCDEF;
    localparam logic [95:0] DATA2  = 96'h0F1E2D3C_A5A5F00F_13579BDF;
    localparam logic [5:0]  H_IDLE = 6'b111111;
    localparam logic [5:0]  H_DATA = 6'b000000;
    localparam logic [5:0]  H_BAD  = 6'b010101;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic locked, overflow;

    frame_sync_if bus();

    frame_sync #(.CONFIRM_CNT(2), .LOSS_CNT(3), .FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s        (bus),
        .locked   (locked),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          bit_no = 0;
    bit          gap_en = 1'b0;
    logic [31:0] exp_q[$];
    int          ovf_at[$];
    frm_t        tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic frm_t mk(input logic [5:0] h, input logic [95:0] p, input bit l, input int e);
        frm_t f;
        f.hdr = h; f.pay = p; f.lock = l; f.emit = e;
        return f;
    endfunction

    // Scoreboard: every pop is compared against the oldest expected word
    always @(negedge clk) begin
        #2;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_word: got %h expected none", bus.out_data);
            end else begin
                check("out_word", bus.out_data, exp_q.pop_front());
            end
        end
    end

    // Record the accepted-bit count at which each overflow pulse appears
    always @(posedge clk) begin
        #1;
        if (overflow) ovf_at.push_back(bit_no);
    end

    task automatic send_bit(input logic b);
        if (gap_en) begin
            while ($urandom_range(1, 0) == 0) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(posedge clk);
        bit_no++;
    endtask

    task automatic send_frame(input frm_t f, input int idx);
        for (int k = 0; k < f.emit; k++) exp_q.push_back(f.pay[95 - 32*k -: 32]);
        for (int i = 0; i < 6; i++) send_bit(f.hdr[5 - i]);
        #1 check($sformatf("locked_frame%0d", idx), {31'd0, locked}, {31'd0, f.lock});
        for (int i = 0; i < 96; i++) send_bit(f.pay[95 - i]);
    endtask

    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) send_frame(tbl[i], i);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bit_no = 0;
    endtask

    task automatic drain(input string name);
        int cyc = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        repeat (10) @(negedge clk);
        check({name, "_pending"}, exp_q.size(), 0);
        check({name, "_empty"}, {31'd0, bus.out_valid}, 32'd0);
        exp_q.delete();
    endtask

    task automatic load_lock_table();
        tbl.delete();
        tbl.push_back(mk(H_IDLE, IDLE_P, 1'b0, 0));
        tbl.push_back(mk(H_IDLE, IDLE_P, 1'b1, 0));
        tbl.push_back(mk(H_DATA, DATA1,  1'b1, 3));
    endtask

    initial begin
        logic [5:0] last;
        logic       b;
        bus.in_valid  = 1'b0;
        bus.in_data   = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_data",  bus.out_data,           32'd0);
        check("rst_locked",    {31'd0, locked},        32'd0);
        check("rst_overflow",  {31'd0, overflow},      32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("in_ready_up", {31'd0, bus.in_ready}, 32'd1);

        // Aligned stream with miss tolerance, loss of lock and relock
        load_lock_table();
        tbl.push_back(mk(H_BAD,  IDLE_P, 1'b1, 0));
        tbl.push_back(mk(H_BAD,  IDLE_P, 1'b1, 0));
        tbl.push_back(mk(H_DATA, DATA2,  1'b1, 3));
        tbl.push_back(mk(H_BAD,  IDLE_P, 1'b1, 0));
        tbl.push_back(mk(H_BAD,  IDLE_P, 1'b1, 0));
        tbl.push_back(mk(H_BAD,  IDLE_P, 1'b0, 0));
        tbl.push_back(mk(H_IDLE, IDLE_P, 1'b0, 0));
        tbl.push_back(mk(H_DATA, DATA1,  1'b1, 3));
        tbl.push_back(mk(H_DATA, DATA2,  1'b1, 3));
        run_table();
        drain("aligned");

        // Same stream with random in_valid gaps
        do_reset();
        gap_en = 1'b1;
        run_table();
        gap_en = 1'b0;
        drain("gapped");

        // Misaligned start: 37 bits with no run of six, first bit 1, last bit 0
        do_reset();
        last = 6'b000000;
        for (int i = 0; i < 37; i++) begin
            b = 1'($urandom_range(1, 0));
            if (i == 0) b = 1'b1;
            else if (i == 36) b = 1'b0;
            else if (i >= 5 && (last[4:0] == 5'b00000 || last[4:0] == 5'b11111)) b = ~last[0];
            last = {last[4:0], b};
            send_bit(b);
            #1 check($sformatf("prefix_lock%0d", i), {31'd0, locked}, 32'd0);
        end
        load_lock_table();
        run_table();
        drain("misaligned");

        // Overflow: stalled sink, two data frames, only the first four words survive
        do_reset();
        bus.out_ready = 1'b0;
        ovf_at.delete();
        load_lock_table();
        tbl.push_back(mk(H_DATA, DATA2, 1'b1, 1));
        run_table();
        repeat (3) @(negedge clk);
        check("ovf_count", ovf_at.size(), 2);
        if (ovf_at.size() == 2) begin
            check("ovf_at_5th", ovf_at[0], 3*102 + 70);
            check("ovf_at_6th", ovf_at[1], 3*102 + 102);
        end
        check("held_valid", {31'd0, bus.out_valid}, 32'd1);
        check("held_data",  bus.out_data, DATA1[95:64]);
        bus.out_ready = 1'b1;
        drain("overflow");

        // Asynchronous reset at payload bit 50 of a data frame
        do_reset();
        bus.out_ready = 1'b0;
        send_frame(mk(H_IDLE, IDLE_P, 1'b0, 0), 0);
        send_frame(mk(H_IDLE, IDLE_P, 1'b1, 0), 1);
        for (int i = 0; i < 6; i++) send_bit(1'b0);
        for (int i = 0; i <= 50; i++) send_bit(DATA1[95 - i]);
        #1;
        check("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
        check("pre_rst_data",  bus.out_data, DATA1[95:64]);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_locked",   {31'd0, locked},        32'd0);
        check("async_valid",    {31'd0, bus.out_valid}, 32'd0);
        check("async_in_ready", {31'd0, bus.in_ready},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1 check("in_ready_rise", {31'd0, bus.in_ready}, 32'd1);
        check("post_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        bit_no = 0;
        bus.out_ready = 1'b1;
        load_lock_table();
        run_table();
        drain("relock");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
